// File: rtl/colour_toggle_ctrl_pkg.sv
// Shared channel indices and defaults for the RGB channel-enable key controller.
// Key bit order matches the DE2 board wiring: KEY[0]=red, KEY[1]=green, KEY[2]=blue.
package colour_ctrl_pkg;

  localparam int CH_RED               = 0;
  localparam int CH_GREEN             = 1;
  localparam int CH_BLUE              = 2;
  localparam int NUM_CH               = 3;
  // 10 ms of stability at 50 MHz
  localparam int DEBOUNCE_CYCLES_DFLT = 500000;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/colour_toggle_ctrl_if.sv
// Key inputs and channel-enable outputs of the colour toggle controller.
// master = board/stimulus side driving keys, slave = the controller.
interface colour_toggle_ctrl_if;

  logic [colour_ctrl_pkg::NUM_CH-1:0] iKEY_N;
  logic                               toggle_red;
  logic                               toggle_green;
  logic                               toggle_blue;
  logic [colour_ctrl_pkg::NUM_CH-1:0] oPRESS;

  modport master (
    output iKEY_N,
    input  toggle_red, toggle_green, toggle_blue, oPRESS
  );

  modport slave (
    input  iKEY_N,
    output toggle_red, toggle_green, toggle_blue, oPRESS
  );

endinterface

// File: rtl/colour_toggle_ctrl_key_debounce.sv
// One key: 2-flop sync, stability counter, post-reset arm and rising-edge detect.
// Latency: stable rises DEBOUNCE_CYCLES+2 edges after the first low sample; oRISE follows it.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = colour_ctrl_pkg::DEBOUNCE_CYCLES_DFLT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iKEY_N,
  output logic oSTABLE,
  output logic oRISE
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic             arm;
  logic [1:0]       prime;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      arm      <= 1'b0;
      prime    <= 2'b00;
      cnt      <= '0;
    end else begin
      sync1    <= ~iKEY_N;
      sync2    <= sync1;
      stable_d <= stable;
      prime    <= {prime[0], 1'b1};

      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // The sync flops come out of reset reading "released", so arming waits until
      // they carry real samples; a key held through reset thus needs a release first.
      if (!stable && !sync2 && prime[1])
        arm <= 1'b1;
    end
  end

  assign oSTABLE = stable;
  assign oRISE   = stable & ~stable_d & arm;

endmodule

// File: rtl/colour_toggle_ctrl.sv
// Three debounced push-buttons flip the red/green/blue channel enables (reset: all on).
// Toggle and oPRESS update one edge after a debounced press is accepted; all outputs registered.
module colour_toggle_ctrl
  import colour_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  colour_toggle_ctrl_if.slave key_if
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  ch_vec_t stable;
  ch_vec_t rise;
  ch_vec_t toggle;
  ch_vec_t press;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .iKEY_N  (key_if.iKEY_N[i]),
      .oSTABLE (stable[i]),
      .oRISE   (rise[i])
    );
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      toggle <= '1;
      press  <= '0;
    end else begin
      press  <= rise & stable;
      toggle <= toggle ^ (rise & stable);
    end
  end

  assign key_if.toggle_red   = toggle[CH_RED];
  assign key_if.toggle_green = toggle[CH_GREEN];
  assign key_if.toggle_blue  = toggle[CH_BLUE];
  assign key_if.oPRESS       = press;

endmodule

// File: tb/tb_colour_toggle_ctrl.sv
// Bench for colour_toggle_ctrl with DEBOUNCE_CYCLES=4: directed scenarios plus random keys,
// every cycle compared against a window-based reference model of the key rules.
module tb_colour_toggle_ctrl;
  import colour_ctrl_pkg::*;

  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  colour_toggle_ctrl_if bus ();

  colour_toggle_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .key_if (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel sample history since reset, accepted level, arm, pending press.
  int         t;
  bit         hist [NUM_CH][$];
  bit         m_stable [NUM_CH];
  bit         m_arm [NUM_CH];
  bit         m_pend [NUM_CH];
  logic [2:0] m_tog   = 3'b111;
  logic [2:0] m_press = 3'b000;

  // Pressed level as seen by the debouncer at edge e (two samples old, released before that).
  function automatic bit seen(input int ch, input int e);
    return (e >= 3) ? hist[ch][e-3] : 1'b0;
  endfunction

  task automatic model_edge(input bit rst, input logic [2:0] key_n);
    if (rst) begin
      t = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        hist[ch].delete();
        m_stable[ch] = 0; m_arm[ch] = 0; m_pend[ch] = 0;
      end
      m_tog = 3'b111; m_press = 3'b000;
      return;
    end
    t++;
    for (int ch = 0; ch < NUM_CH; ch++) hist[ch].push_back(~key_n[ch]);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit flip, new_st, new_arm;
      m_press[ch] = m_pend[ch];
      if (m_pend[ch]) m_tog[ch] = ~m_tog[ch];
      new_arm = m_arm[ch] | (!m_stable[ch] && t >= 3 && !seen(ch, t));
      flip = 1'b1;
      for (int k = 0; k < D; k++)
        if (seen(ch, t - k) == m_stable[ch]) flip = 1'b0;
      new_st = flip ? ~m_stable[ch] : m_stable[ch];
      m_pend[ch]   = new_st & ~m_stable[ch] & new_arm;
      m_stable[ch] = new_st;
      m_arm[ch]    = new_arm;
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {bus.toggle_blue, bus.toggle_green, bus.toggle_red, bus.oPRESS};
  endfunction

  // Drive one cycle's inputs, take the edge, sample 1 time unit later and advance the model.
  task automatic tick(input logic rn, input logic [2:0] key_n);
    rst_n      = rn;
    bus.iKEY_N = key_n;
    @(posedge clk);
    #1;
    model_edge(!rn, key_n);
  endtask

  task automatic test_reset();
    logic [5:0] g;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 3'b111);
      g = dut_out();
      total++;
      if (g !== 6'b111_000) begin bad++; $display("FAIL reset cyc %0d: got %b want %b", i, g, 6'b111_000); end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 3'b111);
      g = dut_out();
      total++;
      if (g !== {m_tog, m_press}) begin bad++; $display("FAIL reset_idle cyc %0d: got %b want %b", i, g, {m_tog, m_press}); end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] g;
    for (int e = 1; e <= 12; e++) begin
      tick(1'b1, 3'b110);
      g = dut_out();
      total++;
      if (g !== {m_tog, m_press}) begin bad++; $display("FAIL clean_model edge %0d: got %b want %b", e, g, {m_tog, m_press}); end
      if (e == 6) begin
        total++;
        if (g !== 6'b111_000) begin bad++; $display("FAIL clean_edge6 got %b want %b", g, 6'b111_000); end
      end
      if (e == 7) begin
        total++;
        if (g !== 6'b110_001) begin bad++; $display("FAIL clean_edge7 got %b want %b", g, 6'b110_001); end
      end
      if (e == 8) begin
        total++;
        if (g !== 6'b110_000) begin bad++; $display("FAIL clean_edge8 got %b want %b", g, 6'b110_000); end
      end
    end
    for (int e = 1; e <= 12; e++) begin
      tick(1'b1, 3'b111);
      g = dut_out();
      total++;
      if (g !== 6'b110_000) begin bad++; $display("FAIL clean_release edge %0d: got %b want %b", e, g, 6'b110_000); end
    end
  endtask

  task automatic test_glitch();
    logic [5:0] g;
    for (int e = 1; e <= 13; e++) begin
      tick(1'b1, (e <= 3) ? 3'b101 : 3'b111);
      g = dut_out();
      total++;
      if (g !== 6'b110_000) begin bad++; $display("FAIL glitch_short edge %0d: got %b want %b", e, g, 6'b110_000); end
    end
    // bounce low, high, then held low from edge 3: four stable samples end at edge 8
    for (int e = 1; e <= 12; e++) begin
      tick(1'b1, (e == 2) ? 3'b111 : 3'b101);
      g = dut_out();
      total++;
      if (g !== {m_tog, m_press}) begin bad++; $display("FAIL bounce_model edge %0d: got %b want %b", e, g, {m_tog, m_press}); end
      if (e == 8) begin
        total++;
        if (g !== 6'b110_000) begin bad++; $display("FAIL bounce_edge8 got %b want %b", g, 6'b110_000); end
      end
      if (e == 9) begin
        total++;
        if (g !== 6'b100_010) begin bad++; $display("FAIL bounce_edge9 got %b want %b", g, 6'b100_010); end
      end
    end
    for (int e = 1; e <= 12; e++) tick(1'b1, 3'b111);
    g = dut_out();
    total++;
    if (g !== 6'b100_000) begin bad++; $display("FAIL bounce_release got %b want %b", g, 6'b100_000); end
  endtask

  task automatic test_simultaneous();
    logic [5:0] g;
    logic [5:0] want7;
    tick(1'b0, 3'b111);
    tick(1'b0, 3'b111);
    for (int e = 0; e < 3; e++) tick(1'b1, 3'b111);
    for (int round = 0; round < 2; round++) begin
      want7 = (round == 0) ? 6'b000_111 : 6'b111_111;
      for (int e = 1; e <= 12; e++) begin
        tick(1'b1, 3'b000);
        g = dut_out();
        total++;
        if (g !== {m_tog, m_press}) begin bad++; $display("FAIL simul_model r%0d edge %0d: got %b want %b", round, e, g, {m_tog, m_press}); end
        if (e == 7) begin
          total++;
          if (g !== want7) begin bad++; $display("FAIL simul_edge7 r%0d got %b want %b", round, g, want7); end
        end
      end
      for (int e = 1; e <= 12; e++) tick(1'b1, 3'b111);
    end
    g = dut_out();
    total++;
    if (g !== 6'b111_000) begin bad++; $display("FAIL simul_restore got %b want %b", g, 6'b111_000); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] g;
    for (int e = 1; e <= 3; e++) tick(1'b1, 3'b110);
    tick(1'b0, 3'b110);
    g = dut_out();
    total++;
    if (g !== 6'b111_000) begin bad++; $display("FAIL midrst_reset got %b want %b", g, 6'b111_000); end
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1, 3'b110);
      g = dut_out();
      total++;
      if (g !== 6'b111_000) begin bad++; $display("FAIL midrst_hold edge %0d: got %b want %b", e, g, 6'b111_000); end
      total++;
      if (g !== {m_tog, m_press}) begin bad++; $display("FAIL midrst_model edge %0d: got %b want %b", e, g, {m_tog, m_press}); end
    end
    for (int e = 1; e <= 12; e++) tick(1'b1, 3'b111);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b1, 3'b110);
      g = dut_out();
      if (e == 6) begin
        total++;
        if (g[3] !== 1'b1) begin bad++; $display("FAIL midrst_repress6 red got %b want 1", g[3]); end
      end
      if (e == 7) begin
        total++;
        if (g !== 6'b110_001) begin bad++; $display("FAIL midrst_repress7 got %b want %b", g, 6'b110_001); end
      end
    end
    for (int e = 1; e <= 12; e++) tick(1'b1, 3'b111);
  endtask

  task automatic test_long_hold();
    logic [5:0] g;
    logic       prev_blue;
    int         flips  = 0;
    int         pulses = 0;
    prev_blue = bus.toggle_blue;
    for (int e = 1; e <= 1000; e++) begin
      tick(1'b1, 3'b011);
      g = dut_out();
      if (g[5] !== prev_blue) flips++;
      if (g[2] === 1'b1) pulses++;
      prev_blue = g[5];
      if (e % 50 == 0 || e < 12) begin
        total++;
        if (g !== {m_tog, m_press}) begin bad++; $display("FAIL long_model edge %0d: got %b want %b", e, g, {m_tog, m_press}); end
      end
    end
    total++;
    if (flips != 1) begin bad++; $display("FAIL long_flips got %0d want 1", flips); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL long_pulses got %0d want 1", pulses); end
    for (int e = 1; e <= 12; e++) tick(1'b1, 3'b111);
  endtask

  task automatic test_random();
    logic [5:0] g;
    logic [2:0] key_n = 3'b111;
    int         hold [NUM_CH];
    logic       rn;
    for (int ch = 0; ch < NUM_CH; ch++) hold[ch] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (hold[ch] == 0) begin
          key_n[ch] = 1'($urandom_range(0, 1));
          hold[ch]  = $urandom_range(1, 9);
        end
        hold[ch]--;
      end
      rn = ($urandom_range(0, 149) != 0);
      tick(rn, key_n);
      g = dut_out();
      total++;
      if (g !== {m_tog, m_press}) begin bad++; $display("FAIL random cyc %0d: got %b want %b", c, g, {m_tog, m_press}); end
    end
  endtask

  initial begin
    bus.iKEY_N = 3'b111;
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
